// File: rtl/gemm_pkg.sv
// Purpose: shared types and constants for the GEMM tile sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: sequencer state enum, default array/count/flag widths and the
//           skew-length helper used to size the systolic wind-down phase.
package gemm_pkg;

    localparam int ARRAY_DIM_DEF  = 4;
    localparam int K_WIDTH_DEF    = 8;
    localparam int FLAG_WIDTH_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_SKEW  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Cycles needed for the last edge operands to ripple across the
    // diagonal of an ad x ad systolic array once feeding has stopped.
    function automatic int skew_len(input int ad);
        return 2 * (ad - 1);
    endfunction

endpackage

// File: rtl/gemm_step_cnt.sv
// Purpose: loadable up-counter that wraps to zero when it reaches a terminal count.
// Latency: count updates on the clock edge after i_en; o_last is combinational on count/term.
// Backpressure: none; the count simply holds while i_en is low.
// Ports: i_clk/i_rst clock and sync reset; i_load/i_load_val synchronous load;
//        i_en advance; i_term terminal value; o_cnt current count; o_last count==term.
module gemm_step_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_term,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_last
);

    logic [WIDTH-1:0] cnt_q;

    assign o_last = (cnt_q == i_term);
    assign o_cnt  = cnt_q;

    // Wrapping at terminal count leaves the counter at zero for the next
    // phase, so the sequencer never has to reload between phases.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= i_load_val;
        end else if (i_en) begin
            cnt_q <= o_last ? '0 : cnt_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/gemm_seq.sv
// Purpose: sequences one GEMM tile on a systolic PE array: clear, feed k steps, skew, drain rows.
// Latency: start to o_done = 1 + k + 2*(ARRAY_DIM-1) + ARRAY_DIM + 1 cycles with no stalls.
// Backpressure: feeder stalls hold RUN (no step counted); i_res_ready low holds the current row.
// Ports: i_clk/i_rst clock and sync active-high reset; i_start/i_cfg_k tile start and step count;
//        i_feed_valid/o_feed_ready feeder handshake; o_feed_zero/o_pe_clr/o_pe_valid PE controls;
//        o_res_valid/i_res_ready/o_res_row result-row readout; o_busy/o_done status;
//        i_pe_flag/o_flag_sticky PE flag accumulation, active only with GEMM_SEQ_FLAG_CHK_EN defined.
module gemm_seq
    import gemm_pkg::*;
#(
    parameter int ARRAY_DIM  = ARRAY_DIM_DEF,
    parameter int K_WIDTH    = K_WIDTH_DEF,
    parameter int FLAG_WIDTH = FLAG_WIDTH_DEF,
    localparam int RW        = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [K_WIDTH-1:0]    i_cfg_k,
    input  logic                  i_feed_valid,
    output logic                  o_feed_ready,
    output logic                  o_feed_zero,
    output logic                  o_pe_clr,
    output logic                  o_pe_valid,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic [RW-1:0]         o_res_row,
    output logic                  o_busy,
    output logic                  o_done,
    input  logic [FLAG_WIDTH-1:0] i_pe_flag,
    output logic [FLAG_WIDTH-1:0] o_flag_sticky
);

    localparam int SKEW_LEN = skew_len(ARRAY_DIM);
    localparam int SKEW_W   = $clog2(SKEW_LEN + 1);
    localparam int CW_A     = (K_WIDTH > RW) ? K_WIDTH : RW;
    localparam int CW       = (CW_A > SKEW_W) ? CW_A : SKEW_W;
    // Terminal values; SKEW is unreachable for a 1x1 array so its term is moot there.
    localparam logic [CW-1:0] SKEW_TERM  = CW'((SKEW_LEN > 0) ? SKEW_LEN - 1 : 0);
    localparam logic [CW-1:0] DRAIN_TERM = CW'(ARRAY_DIM - 1);
    // A 1x1 array has nothing to skew, so feeding goes straight to readout.
    localparam state_t POST_RUN = (SKEW_LEN > 0) ? ST_SKEW : ST_DRAIN;

    state_t           state_q, state_d;
    logic [K_WIDTH-1:0] k_q;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_term;
    logic             cnt_en;
    logic             cnt_last;

    // ---------------- state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Step count is captured only when a start is accepted, so the
    // configuration input is free to change for the rest of the tile.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            k_q <= '0;
        end else if (state_q == ST_IDLE && i_start) begin
            k_q <= i_cfg_k;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (i_start) state_d = ST_CLEAR;
            ST_CLEAR: state_d = (k_q == '0) ? POST_RUN : ST_RUN;
            ST_RUN:   if (i_feed_valid && cnt_last) state_d = POST_RUN;
            ST_SKEW:  if (cnt_last) state_d = ST_DRAIN;
            ST_DRAIN: if (i_res_ready && cnt_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- shared phase counter ----------------
    always_comb begin
        cnt_term = '0;
        cnt_en   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                cnt_term = CW'(k_q) - CW'(1);
                cnt_en   = i_feed_valid;
            end
            ST_SKEW: begin
                cnt_term = SKEW_TERM;
                cnt_en   = 1'b1;
            end
            ST_DRAIN: begin
                cnt_term = DRAIN_TERM;
                cnt_en   = i_res_ready;
            end
            default: begin
                cnt_term = '0;
                cnt_en   = 1'b0;
            end
        endcase
    end

    gemm_step_cnt #(
        .WIDTH (CW)
    ) u_step_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (state_q == ST_CLEAR),
        .i_load_val ('0),
        .i_en       (cnt_en),
        .i_term     (cnt_term),
        .o_cnt      (cnt),
        .o_last     (cnt_last)
    );

    // Only the low bits address a row; the rest matter only for RUN/SKEW.
    logic unused_cnt;
    assign unused_cnt = ^cnt;

    // ---------------- output decode ----------------
    // Everything is decoded from registered state/count; i_feed_valid is
    // the single input allowed to reach an output (o_pe_valid in RUN).
    always_comb begin
        o_feed_ready = 1'b0;
        o_feed_zero  = 1'b0;
        o_pe_clr     = 1'b0;
        o_pe_valid   = 1'b0;
        o_res_valid  = 1'b0;
        o_res_row    = '0;
        o_busy       = (state_q != ST_IDLE);
        o_done       = 1'b0;
        unique case (state_q)
            ST_CLEAR: o_pe_clr = 1'b1;
            ST_RUN: begin
                o_feed_ready = 1'b1;
                o_pe_valid   = i_feed_valid;
            end
            ST_SKEW: begin
                o_pe_valid  = 1'b1;
                o_feed_zero = 1'b1;
            end
            ST_DRAIN: begin
                o_res_valid = 1'b1;
                o_res_row   = cnt[RW-1:0];
            end
            ST_DONE:  o_done = 1'b1;
            default:  ;
        endcase
    end

    // ---------------- PE flag accumulation ----------------
`ifdef GEMM_SEQ_FLAG_CHK_EN
    logic [FLAG_WIDTH-1:0] sticky_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sticky_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            sticky_q <= '0;
        end else if (o_pe_valid) begin
            sticky_q <= sticky_q | i_pe_flag;
        end
    end

    assign o_flag_sticky = sticky_q;
`else
    logic unused_pe_flag;
    assign unused_pe_flag = ^i_pe_flag;
    assign o_flag_sticky  = '0;
`endif

endmodule

// File: tb/tb_gemm_seq.sv
// Purpose: self-checking bench for gemm_seq against a per-tile schedule model.
// Latency: n/a.
// Backpressure: n/a.
// The model derives each phase window from the feed/ready patterns by counting
// handshakes, then predicts every output cycle by cycle.
module tb_gemm_seq;

    localparam int AD = 4;
    localparam int KW = 8;
    localparam int FW = 4;
    localparam int RW = 2;
    localparam int S  = 2 * (AD - 1);
    localparam int N  = 256;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic [KW-1:0] i_cfg_k;
    logic          i_feed_valid;
    logic          o_feed_ready;
    logic          o_feed_zero;
    logic          o_pe_clr;
    logic          o_pe_valid;
    logic          o_res_valid;
    logic          i_res_ready;
    logic [RW-1:0] o_res_row;
    logic          o_busy;
    logic          o_done;
    logic [FW-1:0] i_pe_flag;
    logic [FW-1:0] o_flag_sticky;

    gemm_seq #(
        .ARRAY_DIM  (AD),
        .K_WIDTH    (KW),
        .FLAG_WIDTH (FW)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_cfg_k       (i_cfg_k),
        .i_feed_valid  (i_feed_valid),
        .o_feed_ready  (o_feed_ready),
        .o_feed_zero   (o_feed_zero),
        .o_pe_clr      (o_pe_clr),
        .o_pe_valid    (o_pe_valid),
        .o_res_valid   (o_res_valid),
        .i_res_ready   (i_res_ready),
        .o_res_row     (o_res_row),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .i_pe_flag     (i_pe_flag),
        .o_flag_sticky (o_flag_sticky)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic          v  [N];
    logic          r  [N];
    logic [FW-1:0] fl [N];
    logic [FW-1:0] exp_sticky = '0;

    function automatic logic [FW-1:0] sticky_exp();
`ifdef GEMM_SEQ_FLAG_CHK_EN
        return exp_sticky;
`else
        return '0;
`endif
    endfunction

    // vmode: 0 always valid, 1 toggling 1/0, 2 random
    // rmode: 0 always ready, 1 ready low for 3 cycles on row 2, 2 random
    // fmode: 0 sparse random flags, 1 single 4'b0010 on cycle 3, 2 none
    // rst_at: cycle at which i_rst is pulsed (-1 for none)
    task automatic run_tile(input int k, input int vmode, input int rmode, input int fmode,
                            input int rst_at, output int done_seen, output int pv_seen);
        int run_end, d0, drain_end, done_c, last_c, cnt;
        bit aborted, in_clear, in_run, in_skew, in_drain, in_done, busy, pv;
        int row;

        for (int c = 0; c < N; c++) begin
            case (vmode)
                0:       v[c] = 1'b1;
                1:       v[c] = (c >= 2) ? (((c - 2) % 2) == 0) : 1'b0;
                default: v[c] = (c >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            case (fmode)
                0:       fl[c] = ($urandom_range(0, 5) == 0) ? FW'($urandom) : '0;
                1:       fl[c] = (c == 3) ? 4'b0010 : 4'b0000;
                default: fl[c] = '0;
            endcase
        end

        // RUN ends on the handshake completing step k.
        run_end = 1;
        if (k > 0) begin
            cnt = 0;
            for (int c = 2; c < N; c++) begin
                if (v[c]) cnt++;
                if (cnt == k) begin
                    run_end = c;
                    break;
                end
            end
        end
        d0 = run_end + S + 1;

        for (int c = 0; c < N; c++) begin
            case (rmode)
                0:       r[c] = 1'b1;
                1:       r[c] = !(c >= d0 + 2 && c <= d0 + 4);
                default: r[c] = (c >= 150) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
        end

        drain_end = d0;
        cnt = 0;
        for (int c = d0; c < N; c++) begin
            if (r[c]) cnt++;
            if (cnt == AD) begin
                drain_end = c;
                break;
            end
        end
        done_c = drain_end + 1;
        last_c = (rst_at >= 0) ? rst_at + 3 : done_c + 1;

        done_seen = -1;
        pv_seen   = 0;
        for (int c = 0; c <= last_c; c++) begin
            @(posedge i_clk);
            #1;
            i_rst        = (c == rst_at);
            i_start      = (c == 0) ? 1'b1 :
                           ((c <= done_c && (rst_at < 0 || c <= rst_at)) ? 1'($urandom_range(0, 1)) : 1'b0);
            i_cfg_k      = (c == 0) ? KW'(k) : KW'($urandom);
            i_feed_valid = v[c];
            i_res_ready  = r[c];
            i_pe_flag    = fl[c];
            @(negedge i_clk);

            aborted  = (rst_at >= 0) && (c > rst_at);
            in_clear = !aborted && (c == 1);
            in_run   = !aborted && (c >= 2) && (c <= run_end);
            in_skew  = !aborted && (c > run_end) && (c < d0) && (c >= 2);
            in_drain = !aborted && (c >= d0) && (c <= drain_end);
            in_done  = !aborted && (c == done_c);
            busy     = !aborted && (c >= 1) && (c <= done_c);
            pv       = (in_run && v[c]) || in_skew;
            row = 0;
            if (in_drain)
                for (int j = d0; j < c; j++) if (r[j]) row++;

            check("feed_ready", 32'(o_feed_ready), 32'(in_run));
            check("pe_valid",   32'(o_pe_valid),   32'(pv));
            check("feed_zero",  32'(o_feed_zero),  32'(in_skew));
            check("pe_clr",     32'(o_pe_clr),     32'(in_clear));
            check("res_valid",  32'(o_res_valid),  32'(in_drain));
            check("res_row",    32'(o_res_row),    32'(row));
            check("busy",       32'(o_busy),       32'(busy));
            check("done",       32'(o_done),       32'(in_done));
            check("sticky",     32'(o_flag_sticky), 32'(sticky_exp()));

            if (o_done === 1'b1) done_seen = c;
            if (o_pe_valid === 1'b1) pv_seen++;

            if (c == rst_at)  exp_sticky = '0;
            else if (in_clear) exp_sticky = '0;
            else if (pv)       exp_sticky = exp_sticky | fl[c];
        end
    endtask

    int d, pv;

    initial begin
        i_rst        = 1'b1;
        i_start      = 1'b0;
        i_cfg_k      = '0;
        i_feed_valid = 1'b0;
        i_res_ready  = 1'b0;
        i_pe_flag    = '0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_busy",   32'(o_busy),        32'd0);
        check("rst_row",    32'(o_res_row),     32'd0);
        check("rst_sticky", 32'(o_flag_sticky), 32'd0);
        check("rst_pe_clr", 32'(o_pe_clr),      32'd0);

        // No stalls, k=3: 9 valid cycles, done at cycle 15.
        run_tile(3, 0, 0, 2, -1, d, pv);
        check("k3_done_cycle", 32'(d), 32'd15);
        check("k3_pe_valid_cycles", 32'(pv), 32'd9);

        // Toggling feed, k=5: RUN stretches to 9 cycles.
        run_tile(5, 1, 0, 2, -1, d, pv);
        check("k5_toggle_done_cycle", 32'(d), 32'd21);
        check("k5_toggle_pe_valid", 32'(pv), 32'd11);

        // k=0: CLEAR, skew, drain only.
        run_tile(0, 0, 0, 2, -1, d, pv);
        check("k0_done_cycle", 32'(d), 32'd12);
        check("k0_pe_valid", 32'(pv), 32'd6);

        // Readout stalled on row 2 for three cycles.
        run_tile(2, 0, 1, 2, -1, d, pv);
        check("row_stall_done_cycle", 32'(d), 32'd17);

        // Reset in the middle of SKEW (k=2: SKEW spans cycles 4..9).
        run_tile(2, 0, 0, 0, 6, d, pv);
        check("abort_no_done", 32'(d), 32'hFFFF_FFFF);

        // Following tile runs normally.
        run_tile(3, 0, 0, 2, -1, d, pv);
        check("after_abort_done_cycle", 32'(d), 32'd15);

        // Single flag on one valid RUN cycle.
        run_tile(3, 0, 0, 1, -1, d, pv);
`ifdef GEMM_SEQ_FLAG_CHK_EN
        check("flag_sticky_held", 32'(o_flag_sticky), 32'h2);
`else
        check("flag_sticky_off", 32'(o_flag_sticky), 32'h0);
`endif

        // Randomised tiles.
        for (int t = 0; t < 20; t++) begin
            int kk;
            kk = $urandom_range(0, 12);
            run_tile(kk, 2, 2, 0, -1, d, pv);
            check("rand_done_seen", 32'(d >= 0), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
